// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: frame sequencer for the QPSK transmit path.
// Builds frames of PREAMBLE_LEN alternating +/-AMP symbols, then PAYLOAD_LEN symbols
// from the tx source, then GUARD_LEN zero symbols. Frames leave on a registered
// valid/ready stream, with sof/eof flags registered alongside the data.
module tx_frame_ctrl #(
    parameter int unsigned                  DATA_WIDTH   = 20,
    parameter int unsigned                  PREAMBLE_LEN = 16,
    parameter int unsigned                  PAYLOAD_LEN  = 256,
    parameter int unsigned                  GUARD_LEN    = 8,
    parameter logic signed [DATA_WIDTH-1:0] AMP          = 20'sd131072,
    parameter int unsigned                  CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         cont,
    input  logic                         abort,
    input  logic signed [DATA_WIDTH-1:0] src_i,
    input  logic signed [DATA_WIDTH-1:0] src_q,
    output logic                         src_en,
    output logic signed [DATA_WIDTH-1:0] out_i,
    output logic signed [DATA_WIDTH-1:0] out_q,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sof,
    output logic                         out_eof,
    output logic                         busy,
    output logic [CNT_W-1:0]             frame_cnt
);

    // Last sym_cnt value of each section; sym_cnt shares the frame counter width.
    localparam logic [CNT_W-1:0] PreLast = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] PayLast = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [CNT_W-1:0] GrdLast = CNT_W'(GUARD_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StPayload,
        StGuard
    } state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               sym_cnt_q, sym_cnt_d;
    logic signed [DATA_WIDTH-1:0]   out_i_q, out_i_d;
    logic signed [DATA_WIDTH-1:0]   out_q_q, out_q_d;
    logic                           out_valid_q, out_valid_d;
    logic                           out_sof_q, out_sof_d;
    logic                           out_eof_q, out_eof_d;
    logic [CNT_W-1:0]               frame_cnt_q, frame_cnt_d;
    logic                           load;

    // Output register may take a new symbol when it is empty or being drained.
    always_comb begin
        load   = (state_q != StIdle) && (!out_valid_q || out_ready);
        // The source advances once per captured payload symbol, never during abort.
        src_en = load && (state_q == StPayload) && !abort;
    end

    // Next-state: sequencing, output register contents and frame counting.
    always_comb begin
        state_d     = state_q;
        sym_cnt_d   = sym_cnt_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        frame_cnt_d = frame_cnt_q;

        if (abort) begin
            // Abort wins over start and over a same-cycle final guard load.
            state_d     = StIdle;
            sym_cnt_d   = '0;
            out_valid_d = 1'b0;
            out_sof_d   = 1'b0;
            out_eof_d   = 1'b0;
        end else begin
            // Sample drained with nothing new to replace it.
            if (!load && out_ready) begin
                out_valid_d = 1'b0;
                out_sof_d   = 1'b0;
                out_eof_d   = 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d   = StPreamble;
                        sym_cnt_d = '0;
                    end
                end

                StPreamble: begin
                    if (load) begin
                        out_i_d     = sym_cnt_q[0] ? -AMP : AMP;
                        out_q_d     = AMP;
                        out_valid_d = 1'b1;
                        out_sof_d   = (sym_cnt_q == '0);
                        out_eof_d   = 1'b0;
                        if (sym_cnt_q == PreLast) begin
                            state_d   = StPayload;
                            sym_cnt_d = '0;
                        end else begin
                            sym_cnt_d = sym_cnt_q + CNT_W'(1);
                        end
                    end
                end

                StPayload: begin
                    if (load) begin
                        out_i_d     = src_i;
                        out_q_d     = src_q;
                        out_valid_d = 1'b1;
                        out_sof_d   = 1'b0;
                        out_eof_d   = 1'b0;
                        if (sym_cnt_q == PayLast) begin
                            state_d   = StGuard;
                            sym_cnt_d = '0;
                        end else begin
                            sym_cnt_d = sym_cnt_q + CNT_W'(1);
                        end
                    end
                end

                StGuard: begin
                    if (load) begin
                        out_i_d     = '0;
                        out_q_d     = '0;
                        out_valid_d = 1'b1;
                        out_sof_d   = 1'b0;
                        out_eof_d   = (sym_cnt_q == GrdLast);
                        if (sym_cnt_q == GrdLast) begin
                            frame_cnt_d = frame_cnt_q + CNT_W'(1);
                            sym_cnt_d   = '0;
                            // Continuous mode chains straight into the next preamble.
                            state_d     = cont ? StPreamble : StIdle;
                        end else begin
                            sym_cnt_d = sym_cnt_q + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state_d   = StIdle;
                    sym_cnt_d = '0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sym_cnt_q   <= '0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign busy      = (state_q != StIdle);
    assign frame_cnt = frame_cnt_q;

    // A stalled sample must stay put until accepted (unless aborted).
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !out_ready && !abort) |=>
            (out_valid_q && $stable(out_i_q) && $stable(out_q_q) &&
             $stable(out_sof_q) && $stable(out_eof_q)));

    // The source only advances while payload is being captured.
    a_src_en_payload: assert property (@(posedge clk) disable iff (!rst_n)
        src_en |-> (state_q == StPayload));

    // Abort empties the stream and parks the sequencer.
    a_abort_idle: assert property (@(posedge clk) disable iff (!rst_n)
        abort |=> (!out_valid_q && state_q == StIdle));

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Bench for tx_frame_ctrl: PRBS9-driven symbol source, accepted-stream scoreboard
// against a frame-level model, plus hand sequences for abort, wrap and async reset.
module tb_tx_frame_ctrl;

    localparam int DW   = 20;
    localparam int PRE  = 16;
    localparam int PAY  = 256;
    localparam int GRD  = 8;
    localparam int FLEN = PRE + PAY + GRD;
    localparam int AMP  = 131072;
    localparam int QA   = 92682;
    localparam int TAB  = 4096;

    typedef struct packed {
        logic signed [DW-1:0] i;
        logic signed [DW-1:0] q;
        logic                 sof;
        logic                 eof;
    } samp_t;

    typedef struct {
        int                   pos;
        logic signed [DW-1:0] i;
        logic signed [DW-1:0] q;
        logic                 sof;
        logic                 eof;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0, cont = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic signed [DW-1:0] src_i, src_q, out_i, out_q;
    logic                 src_en, out_valid, out_sof, out_eof, busy;
    logic [15:0]          frame_cnt;

    logic                 w_start = 1'b0, w_cont = 1'b0, w_abort = 1'b0, w_ready = 1'b1;
    logic signed [DW-1:0] w_src_i = '0, w_src_q = '0, w_out_i, w_out_q;
    logic                 w_src_en, w_valid, w_sof, w_eof, w_busy;
    logic [1:0]           w_frame_cnt;

    logic signed [DW-1:0] sym_i_tab [TAB];
    logic signed [DW-1:0] sym_q_tab [TAB];
    int                   src_idx = 0;

    int    n_tests = 0, n_fail = 0;
    int    cyc = 0, en_count = 0, eof_seen = 0;
    int    stall_checks = 0, stall_err = 0;
    logic  stall_prev = 1'b0;
    samp_t held;
    samp_t acc_q[$];
    int    acc_cyc[$];
    samp_t exp_q[$];
    logic [1:0] w_fc_prev = '0;
    int    w_fc_q[$];
    int    w_sof_cnt = 0;
    bit    rnd_ready = 1'b0;

    always #5 clk = ~clk;

    tx_frame_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .src_i(src_i), .src_q(src_q), .src_en(src_en),
        .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .frame_cnt(frame_cnt)
    );

    tx_frame_ctrl #(
        .PREAMBLE_LEN(2), .PAYLOAD_LEN(3), .GUARD_LEN(1), .CNT_W(2)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(w_start), .cont(w_cont), .abort(w_abort),
        .src_i(w_src_i), .src_q(w_src_q), .src_en(w_src_en),
        .out_i(w_out_i), .out_q(w_out_q), .out_valid(w_valid), .out_ready(w_ready),
        .out_sof(w_sof), .out_eof(w_eof), .busy(w_busy), .frame_cnt(w_frame_cnt)
    );

    // Tx symbol source: combinational from its PRBS position, advanced by src_en.
    assign src_i = sym_i_tab[src_idx % TAB];
    assign src_q = sym_q_tab[src_idx % TAB];
    always @(posedge clk) if (src_en) src_idx <= src_idx + 1;

    // Monitor: capture accepted samples, count src_en, check stall stability.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                stall_checks = stall_checks + 1;
                if (!out_valid || samp_t'({out_i, out_q, out_sof, out_eof}) !== held)
                    stall_err = stall_err + 1;
            end
            held = samp_t'({out_i, out_q, out_sof, out_eof});
            stall_prev = out_valid && !out_ready && !abort;
            if (out_valid && out_ready) begin
                acc_q.push_back(held);
                acc_cyc.push_back(cyc);
                if (out_eof) eof_seen = eof_seen + 1;
            end
            if (src_en) en_count = en_count + 1;
            if (w_frame_cnt != w_fc_prev) w_fc_q.push_back(int'(w_frame_cnt));
            w_fc_prev = w_frame_cnt;
            if (w_valid && w_ready && w_sof) w_sof_cnt = w_sof_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((busy || out_valid) && n < budget) begin
            tick();
            n++;
        end
        check({name, " completes"}, 64'(n < budget), 1);
    endtask

    function automatic samp_t get_acc(input int idx);
        samp_t z = '0;
        if (idx < acc_q.size()) return acc_q[idx];
        return z;
    endfunction

    // Frame model: preamble, then payload symbols base.., then zero guard.
    task automatic build_frames(input int base, input int nframes);
        samp_t s;
        exp_q.delete();
        for (int f = 0; f < nframes; f++) begin
            for (int k = 0; k < PRE; k++) begin
                s.i = (k % 2 == 0) ? DW'(AMP) : DW'(-AMP);
                s.q = DW'(AMP);
                s.sof = (k == 0);
                s.eof = 1'b0;
                exp_q.push_back(s);
            end
            for (int k = 0; k < PAY; k++) begin
                s.i = sym_i_tab[(base + f * PAY + k) % TAB];
                s.q = sym_q_tab[(base + f * PAY + k) % TAB];
                s.sof = 1'b0;
                s.eof = 1'b0;
                exp_q.push_back(s);
            end
            for (int k = 0; k < GRD; k++) begin
                s = '0;
                s.eof = (k == GRD - 1);
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic compare_stream(input string name, input int acc0, input int base,
                                  input int nframes);
        int mism = 0;
        int first = -1;
        build_frames(base, nframes);
        check({name, " length"}, 64'(acc_q.size() - acc0), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            if (get_acc(acc0 + k) !== exp_q[k]) begin
                mism++;
                if (first < 0) first = k;
            end
        end
        check({name, " sample errors"}, 64'(mism), 0);
        if (mism != 0) $display("  %s first bad sample index %0d", name, first);
        if (acc_q.size() - acc0 == exp_q.size() && exp_q.size() > 0)
            check({name, " contiguous"}, 64'(acc_cyc[acc_q.size() - 1] - acc_cyc[acc0]),
                  64'(exp_q.size() - 1));
    endtask

    initial begin
        logic [8:0] li, lq;
        logic       bi, bq;
        vec_t       vecs[8];
        samp_t      a;
        int         acc0, en0, eof0, n, starts;
        logic       pb;
        int         wexp[5];

        li = 9'h1AA;
        lq = 9'h1FE;
        for (int k = 0; k < TAB; k++) begin
            bi = li[8] ^ li[4];
            li = {li[7:0], bi};
            bq = lq[8] ^ lq[4];
            lq = {lq[7:0], bq};
            sym_i_tab[k] = bi ? DW'(-QA) : DW'(QA);
            sym_q_tab[k] = bq ? DW'(-QA) : DW'(QA);
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset frame_cnt", frame_cnt, 0);
        check("reset out_i", out_i, 0);
        check("reset src_en", src_en, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single frame, ready always high.
        acc0 = acc_q.size();
        en0 = en_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1 valid 1 cycle after start", out_valid, 0);
        check("t1 busy after start", busy, 1);
        tick();
        check("t1 valid 2 cycles after start", out_valid, 1);
        check("t1 sof on first sample", out_sof, 1);
        wait_done("t1", 2000);
        compare_stream("t1", acc0, 0, 1);
        check("t1 frame_cnt", frame_cnt, 1);
        check("t1 busy", busy, 0);
        check("t1 src_en count", 64'(en_count - en0), PAY);

        vecs[0] = '{0,   DW'(AMP),  DW'(AMP), 1'b1, 1'b0};
        vecs[1] = '{1,   DW'(-AMP), DW'(AMP), 1'b0, 1'b0};
        vecs[2] = '{14,  DW'(AMP),  DW'(AMP), 1'b0, 1'b0};
        vecs[3] = '{15,  DW'(-AMP), DW'(AMP), 1'b0, 1'b0};
        vecs[4] = '{16,  sym_i_tab[0],   sym_q_tab[0],   1'b0, 1'b0};
        vecs[5] = '{271, sym_i_tab[255], sym_q_tab[255], 1'b0, 1'b0};
        vecs[6] = '{272, '0, '0, 1'b0, 1'b0};
        vecs[7] = '{279, '0, '0, 1'b0, 1'b1};
        for (int v = 0; v < 8; v++) begin
            a = get_acc(acc0 + vecs[v].pos);
            check($sformatf("vec%0d i", v), a.i, vecs[v].i);
            check($sformatf("vec%0d q", v), a.q, vecs[v].q);
            check($sformatf("vec%0d sof", v), a.sof, vecs[v].sof);
            check($sformatf("vec%0d eof", v), a.eof, vecs[v].eof);
        end

        // Random backpressure: same frame shape, source continues.
        rnd_ready = 1'b1;
        acc0 = acc_q.size();
        en0 = en_count;
        pulse_start();
        wait_done("t2", 5000);
        rnd_ready = 1'b0;
        tick();
        build_frames(PAY, 1);
        check("t2 length", 64'(acc_q.size() - acc0), FLEN);
        n = 0;
        for (int k = 0; k < FLEN; k++) if (get_acc(acc0 + k) !== exp_q[k]) n++;
        check("t2 sample errors", 64'(n), 0);
        check("t2 src_en count", 64'(en_count - en0), PAY);
        check("t2 frame_cnt", frame_cnt, 2);
        check("t2 stalls observed", 64'(stall_checks > 0), 1);

        // Continuous mode, three frames back to back.
        acc0 = acc_q.size();
        en0 = en_count;
        eof0 = eof_seen;
        cont = 1'b1;
        pulse_start();
        n = 0;
        while (eof_seen - eof0 < 2 && n < 2000) begin
            tick();
            n++;
        end
        check("t3 two frames in budget", 64'(n < 2000), 1);
        cont = 1'b0;
        wait_done("t3", 2000);
        compare_stream("t3", acc0, 2 * PAY, 3);
        a = get_acc(acc0 + 280);
        check("t3 sof at 280", a.sof, 1);
        a = get_acc(acc0 + 559);
        check("t3 eof at 559", a.eof, 1);
        check("t3 frame_cnt", frame_cnt, 5);
        check("t3 src_en count", 64'(en_count - en0), 3 * PAY);

        // Abort with payload symbol 100 in the output register.
        en0 = en_count;
        pulse_start();
        n = 0;
        while (en_count - en0 < 101 && n < 1000) begin
            tick();
            n++;
        end
        check("t4 reached payload 100", 64'(n < 1000), 1);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("t4 valid after abort", out_valid, 0);
        check("t4 busy after abort", busy, 0);
        check("t4 frame_cnt after abort", frame_cnt, 5);
        check("t4 src_en held in abort", 64'(en_count - en0), 101);
        tick();
        check("t4 stays idle", busy, 0);
        acc0 = acc_q.size();
        pulse_start();
        wait_done("t4", 2000);
        compare_stream("t4 resume", acc0, 5 * PAY + 101, 1);
        check("t4 frame_cnt", frame_cnt, 6);

        // Narrow counter wrap with start held high.
        w_start = 1'b1;
        starts = 0;
        pb = 1'b0;
        n = 0;
        while (starts < 5 && n < 300) begin
            tick();
            n++;
            if (w_busy && !pb) starts++;
            pb = w_busy;
        end
        w_start = 1'b0;
        n = 0;
        while ((w_busy || w_valid) && n < 100) begin
            tick();
            n++;
        end
        tick();
        check("t5 finished", 64'(n < 100), 1);
        check("t5 frames", 64'(w_sof_cnt), 5);
        check("t5 frame_cnt changes", 64'(w_fc_q.size()), 5);
        wexp = '{1, 2, 3, 0, 1};
        for (int k = 0; k < 5; k++)
            if (k < w_fc_q.size()) check($sformatf("t5 frame_cnt seq %0d", k),
                                         64'(w_fc_q[k]), 64'(wexp[k]));
        check("t5 final frame_cnt", w_frame_cnt, 1);

        // Asynchronous reset in the middle of the payload.
        en0 = en_count;
        pulse_start();
        n = 0;
        while (en_count - en0 < 50 && n < 500) begin
            tick();
            n++;
        end
        check("t6 valid before reset", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6 async valid", out_valid, 0);
        check("t6 async out_i", out_i, 0);
        check("t6 async out_q", out_q, 0);
        check("t6 async busy", busy, 0);
        check("t6 async frame_cnt", frame_cnt, 0);
        check("t6 async src_en", src_en, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("t6 idle after release", busy, 0);
        check("t6 no valid after release", out_valid, 0);
        pulse_start();
        check("t6 start after release", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        check("stall stability violations", 64'(stall_err), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
